fetch_seq: RTL
==============

# fetch_seq

Multi-cycle instruction sequencer and PC unit, directly upstream of the execute/register stage. It owns the program counter and fetches from a synchronous-read instruction memory, presenting `instruction_o`/`pc_plus4_o` to execute. It drives the `mode_o` phase code (execute acts only in mode 5) and resolves jump/branch results returned by execute into the next PC. It also owns the global cycle counter and the halt-on-exception latch.

## Interface
- `RESET_PC`, 32'h0000_0000: byte address of the first fetch after reset.
- `IMEM_AW`, 14: instruction memory word-address width; PC byte range is 0 .. 2^(IMEM_AW+2)-1.
- `clk_i` in 1: single clock. All state updates on the rising edge except the two falling-edge capture flops in Operation.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `run_i` in 1: level start; sampled in IDLE.
- `imem_addr_o` out IMEM_AW: word address `pc[IMEM_AW+1:2]`.
- `imem_data_i` in 32: instruction word, valid one cycle after the address.
- `mode_o` out 4: phase code; 0 IDLE, 1 FETCH, 2 LATCH, 5 EXEC, 6 MEM, 15 HALT.
- `instruction_o` out 32: latched instruction.
- `pc_plus4_o` out 32: PC of the latched instruction + 4.
- `j_valid_i`, `j_addr_i[25:0]`, `b_valid_i`, `b_addr_i[15:0]` in: jump/branch results from execute.
- `exc_code_i` in 4: break code; nonzero only during the high phase of EXEC.
- `set_cnt_i` in 1: cycle counter clear request; high-phase pulse.
- `cycle_cnt_o` out 32: cycles elapsed since run start or the last clear.
- `halted_o` out 1: HALT state flag.
- `exc_code_o` out 4: sticky exception code, valid while halted.

## Operation
- State machine, one state per mode value:
  - IDLE→FETCH when `run_i`=1.
  - FETCH→LATCH unconditionally.
  - LATCH→EXEC unconditionally; `instruction_o` is loaded from `imem_data_i` here.
  - EXEC→MEM unconditionally.
  - MEM→FETCH, or →HALT if an exception is pending.
  - HALT→IDLE only through reset.
- Next-PC is computed at the EXEC→MEM edge, with p4 = `pc_plus4_o`:
  - `j_valid_i` and latched instruction is jr (opcode 0, funct 6'b001000): pc = {6'b0, `j_addr_i`} (byte address).
  - `j_valid_i`, any other instruction (j/jal): pc = {p4[31:28], `j_addr_i`, 2'b00}.
  - Else `b_valid_i`: pc = p4 + (sign-extended `b_addr_i` << 2), modulo 2^32.
  - Else pc = p4.
  - If `j_valid_i` and `b_valid_i` are both high, jump wins.
- Falling-edge capture:
  - While `mode_o`=5, the falling edge captures `exc_code_i` (if nonzero) into `exc_pend` and ORs `set_cnt_i` into `clr_pend`.
  - Both are consumed at the next rising edge and cleared on leaving EXEC.
- PC range check, at the MEM→FETCH decision:
  - Next pc with bits above IMEM_AW+1 set, or bits [1:0] ≠ 0, forces HALT with `exc_code_o`=4'hE.
  - A pending break code takes priority over the range check.
- Cycle counter:
  - Increments by 1 every rising edge in FETCH, LATCH, EXEC and MEM; wraps at 2^32.
  - `clr_pend` at the EXEC→MEM edge loads 0 instead of incrementing.
  - Holds in IDLE and HALT.
  - Cleared on IDLE→FETCH.

## Timing
- Reset values: `mode_o`=0, pc=`RESET_PC`, `instruction_o`=0, `pc_plus4_o`=`RESET_PC`+4, `cycle_cnt_o`=0, `halted_o`=0, `exc_code_o`=0.
- Throughput: exactly 4 cycles per instruction (FETCH, LATCH, EXEC, MEM); no stalls.
- `imem_addr_o` is registered from pc. `instruction_o` is stable from LATCH exit through MEM end.
- `pc_plus4_o` updates together with `instruction_o`.
- HALT entered from MEM: `halted_o` rises on the same edge that `mode_o` becomes 15. `exc_code_o` holds the captured code.
- Reset asserted mid-instruction: all registers return to reset values asynchronously, including `exc_pend` and `clr_pend`. The FSM restarts in IDLE.

## Structure
- Shared package `cpu_pkg`:
  - Mode constants MODE_IDLE=0, FETCH=1, LATCH=2, EXEC=5, MEM=6, HALT=15.
  - Opcode/funct constants OP_SPECIAL, FN_JR, OP_J, OP_JAL.
  - Exception code EXC_PC_RANGE=4'hE.
- Sub-module `next_pc_calc`: purely combinational next-PC mux plus range check. The FSM, counter and capture flops stay in `fetch_seq`.

## Test plan
- Reset then `run_i`=1, memory holds 4 NOPs at 0x0: `mode_o` sequence 1,2,5,6 repeats; pc advances 0,4,8,C; `cycle_cnt_o`=8 after 2 instructions.
- beq at 0x10, `b_valid_i`=1, `b_addr_i`=16'hFFFC: next fetch at 0x04. Same with `b_addr_i`=16'h0003: next fetch at 0x20.
- jal at 0x08, `j_addr_i`=26'h40: `pc_plus4_o`=0x0C during EXEC; next fetch at 0x100.
- jr, `j_addr_i`=26'h24: next fetch at 0x24. `j_valid_i`=`b_valid_i`=1 with j target 0x40, b target 0x80: fetch at 0x40.
- `exc_code_i`=4'h3 pulsed in EXEC high phase: after MEM, `mode_o`=15, `halted_o`=1, `exc_code_o`=3, `cycle_cnt_o` frozen. jr to 0x0001_0000 with IMEM_AW=14: HALT with code 4'hE.
- `set_cnt_i` pulse in EXEC: `cycle_cnt_o`=0 after the EXEC→MEM edge, then 1 at end of MEM. `rst_n_i` low during EXEC: immediate return to all reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU front end: phase codes, opcode decode and exception codes.
package cpu_pkg;

    localparam logic [3:0] MODE_IDLE  = 4'd0;
    localparam logic [3:0] MODE_FETCH = 4'd1;
    localparam logic [3:0] MODE_LATCH = 4'd2;
    localparam logic [3:0] MODE_EXEC  = 4'd5;
    localparam logic [3:0] MODE_MEM   = 4'd6;
    localparam logic [3:0] MODE_HALT  = 4'd15;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;

    localparam logic [3:0] EXC_NONE     = 4'h0;
    localparam logic [3:0] EXC_PC_RANGE = 4'hE;

    function automatic logic is_jr(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_SPECIAL) && (funct == FN_JR);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection (jump > branch > sequential) with fetch-range check.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_AW = 14
) (
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    input  logic [31:0] i_pc_plus4,
    input  logic        i_j_valid,
    input  logic [25:0] i_j_addr,
    input  logic        i_b_valid,
    input  logic [15:0] i_b_addr,
    output logic [31:0] o_next_pc,
    output logic        o_range_err
);

    logic [31:0] w_b_offset;

    assign w_b_offset = {{14{i_b_addr[15]}}, i_b_addr, 2'b00};

    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_j_valid) begin
            // jr carries a full byte address; j/jal carry a word index within the 256 MB region
            if (is_jr(i_opcode, i_funct)) begin
                o_next_pc = {6'b0, i_j_addr};
            end else begin
                o_next_pc = {i_pc_plus4[31:28], i_j_addr, 2'b00};
            end
        end else if (i_b_valid) begin
            o_next_pc = i_pc_plus4 + w_b_offset;
        end
    end

    assign o_range_err = ((o_next_pc >> (IMEM_AW + 2)) != 32'd0) || (o_next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_seq.sv
// Four-phase instruction sequencer: owns the PC, instruction latch, cycle counter and halt latch.
module fetch_seq
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 14
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               run_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_data_i,
    output logic [3:0]         mode_o,
    output logic [31:0]        instruction_o,
    output logic [31:0]        pc_plus4_o,
    input  logic               j_valid_i,
    input  logic [25:0]        j_addr_i,
    input  logic               b_valid_i,
    input  logic [15:0]        b_addr_i,
    input  logic [3:0]         exc_code_i,
    input  logic               set_cnt_i,
    output logic [31:0]        cycle_cnt_o,
    output logic               halted_o,
    output logic [3:0]         exc_code_o
);

    logic [3:0]         r_mode;
    logic [31:0]        r_pc;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [31:0]        r_instr;
    logic [31:0]        r_pc_plus4;
    logic [31:0]        r_cnt;
    logic [3:0]         r_exc_code;
    logic [3:0]         r_exc_pend;
    logic               r_clr_pend;

    logic [3:0]         w_next_mode;
    logic [31:0]        w_next_pc;
    logic               w_range_err;

    next_pc_calc #(
        .IMEM_AW (IMEM_AW)
    ) u_next_pc_calc (
        .i_opcode    (r_instr[31:26]),
        .i_funct     (r_instr[5:0]),
        .i_pc_plus4  (r_pc_plus4),
        .i_j_valid   (j_valid_i),
        .i_j_addr    (j_addr_i),
        .i_b_valid   (b_valid_i),
        .i_b_addr    (b_addr_i),
        .o_next_pc   (w_next_pc),
        .o_range_err (w_range_err)
    );

    // r_exc_code is only ever nonzero once a halt has been decided
    always_comb begin
        w_next_mode = r_mode;
        case (r_mode)
            MODE_IDLE:  if (run_i) w_next_mode = MODE_FETCH;
            MODE_FETCH: w_next_mode = MODE_LATCH;
            MODE_LATCH: w_next_mode = MODE_EXEC;
            MODE_EXEC:  w_next_mode = MODE_MEM;
            MODE_MEM:   w_next_mode = (r_exc_code != EXC_NONE) ? MODE_HALT : MODE_FETCH;
            MODE_HALT:  w_next_mode = MODE_HALT;
            default:    w_next_mode = MODE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mode      <= MODE_IDLE;
            r_pc        <= RESET_PC;
            r_imem_addr <= RESET_PC[IMEM_AW+1:2];
            r_instr     <= 32'd0;
            r_pc_plus4  <= RESET_PC + 32'd4;
            r_cnt       <= 32'd0;
            r_exc_code  <= EXC_NONE;
        end else begin
            r_mode <= w_next_mode;
            case (r_mode)
                MODE_IDLE: begin
                    if (run_i) r_cnt <= 32'd0;
                end
                MODE_FETCH: begin
                    r_cnt <= r_cnt + 32'd1;
                end
                MODE_LATCH: begin
                    r_cnt      <= r_cnt + 32'd1;
                    r_instr    <= imem_data_i;
                    r_pc_plus4 <= r_pc + 32'd4;
                end
                MODE_EXEC: begin
                    r_cnt       <= r_clr_pend ? 32'd0 : r_cnt + 32'd1;
                    r_pc        <= w_next_pc;
                    r_imem_addr <= w_next_pc[IMEM_AW+1:2];
                    if (r_exc_pend != EXC_NONE) begin
                        r_exc_code <= r_exc_pend;
                    end else if (w_range_err) begin
                        r_exc_code <= EXC_PC_RANGE;
                    end
                end
                MODE_MEM: begin
                    r_cnt <= r_cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Execute raises break/clear requests in the high phase; capture them on the falling edge
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_exc_pend <= EXC_NONE;
            r_clr_pend <= 1'b0;
        end else if (r_mode == MODE_EXEC) begin
            if (exc_code_i != EXC_NONE) r_exc_pend <= exc_code_i;
            r_clr_pend <= r_clr_pend | set_cnt_i;
        end else begin
            r_exc_pend <= EXC_NONE;
            r_clr_pend <= 1'b0;
        end
    end

    assign imem_addr_o   = r_imem_addr;
    assign mode_o        = r_mode;
    assign instruction_o = r_instr;
    assign pc_plus4_o    = r_pc_plus4;
    assign cycle_cnt_o   = r_cnt;
    assign halted_o      = (r_mode == MODE_HALT);
    assign exc_code_o    = r_exc_code;

endmodule
